// File: rtl/attention_token_precision_select.sv
// attention_token_precision_select: per-token attention column sums classified into INT4/INT8/FP16 codes.
module attention_token_precision_select #(
  parameter int DATA_WIDTH = 16,
  parameter int L = 8,
  parameter int N = 1,
  parameter int ACC_WIDTH = DATA_WIDTH + $clog2(L*N) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_WIDTH*L*N*L-1:0]  A_in,
  input  logic [ACC_WIDTH-1:0]         thr_lo,
  input  logic [ACC_WIDTH-1:0]         thr_hi,
  output logic [3:0]                   token_precision [L],
  output logic                         done,
  output logic                         out_valid
);
  localparam int RW = (L*N > 1) ? $clog2(L*N) : 1;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACCUM, S_CLASSIFY, S_DONE} state_t;
  state_t                        r_state, w_next;
  logic [DATA_WIDTH*L*N*L-1:0]   r_a;
  logic [ACC_WIDTH-1:0]          r_lo, r_hi;
  logic [ACC_WIDTH-1:0]          r_acc [L];
  logic [RW-1:0]                 r_row;
  logic                          w_last;
  logic [L*DATA_WIDTH-1:0]       w_row;
  // row r covers (l=r/N, n=r%N), whose L elements are contiguous at offset r*L
  assign w_row = r_a[r_row*L*DATA_WIDTH +: L*DATA_WIDTH];
  assign w_last = r_row == RW'(L*N-1);
  assign done = r_state == S_DONE;
  assign out_valid = r_state == S_DONE;
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:     w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:     w_next = S_ACCUM;
      S_ACCUM:    w_next = w_last ? S_CLASSIFY : S_ACCUM;
      S_CLASSIFY: w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row <= '0;
      r_acc <= '{default: '0};
      token_precision <= '{default: 4'd2};
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD) begin
        r_a <= A_in;
        r_lo <= thr_lo;
        r_hi <= thr_hi;
        r_row <= '0;
        r_acc <= '{default: '0};
      end
      if (r_state == S_ACCUM) begin
        r_row <= w_last ? '0 : r_row + 1'b1;
        for (int j = 0; j < L; j++)
          r_acc[j] <= r_acc[j] + {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, w_row[j*DATA_WIDTH +: DATA_WIDTH]};
      end
      if (r_state == S_CLASSIFY)
        for (int j = 0; j < L; j++)
          token_precision[j] <= (r_acc[j] >= r_hi) ? 4'd2 : (r_acc[j] >= r_lo) ? 4'd1 : 4'd0;
    end
  end
endmodule

// File: tb/tb_attention_token_precision_select.sv
// tb_attention_token_precision_select: directed runs with a done-driven scoreboard monitor.
module tb_attention_token_precision_select;
  localparam int DW = 16, L = 8, N = 1, AW = DW*L*N*L, ACW = 20;
  logic           clk = 0, rst = 1, start = 0;
  logic [AW-1:0]  A_in = '0;
  logic [ACW-1:0] thr_lo = '0, thr_hi = '0;
  logic [3:0]     token_precision [L];
  logic           done, out_valid;
  int             checks = 0, errors = 0;
  logic [31:0]    q [$];
  attention_token_precision_select #(.DATA_WIDTH(DW), .L(L), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A_in(A_in), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .token_precision(token_precision), .done(done), .out_valid(out_valid));
  always #5 clk = ~clk;
  function automatic logic [31:0] tp_packed();
    logic [31:0] v;
    for (int i = 0; i < L; i++) v[i*4 +: 4] = token_precision[i];
    return v;
  endfunction
  function automatic logic [AW-1:0] make_a(input logic [15:0] c0, c1, cr);
    logic [AW-1:0] a;
    for (int r = 0; r < L*N; r++)
      for (int j = 0; j < L; j++)
        a[(r*L+j)*DW +: DW] = (j == 0) ? c0 : (j == 1) ? c1 : cr;
    return a;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done || out_valid) begin
      chk("out_valid_eq_done", {31'b0, out_valid}, {31'b0, done});
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("codes", tp_packed(), q.pop_front());
    end
  end
  // mode 0: plain run; 1: busy start plus input change mid-run; 2: check codes held mid-run
  task automatic run(input logic [AW-1:0] a, input logic [ACW-1:0] lo, hi,
                     input logic [31:0] exp, input int mode, input logic [31:0] hold);
    int n;
    @(negedge clk);
    A_in = a; thr_lo = lo; thr_hi = hi; start = 1;
    q.push_back(exp);
    @(negedge clk);
    start = 0;
    n = 1;
    while (!done && n < 40) begin
      if (mode == 1 && n == 4) begin
        start = 1; A_in = make_a(16'h1000, 16'h1000, 16'h1000); thr_hi = '0; thr_lo = '0;
      end else start = 0;
      if (mode == 2 && n == 5) chk("hold_prev_codes", tp_packed(), hold);
      @(negedge clk);
      n++;
    end
    chk("latency", n, 11);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int n;
    @(negedge clk); @(negedge clk);
    chk("reset_codes", tp_packed(), 32'h22222222);
    chk("reset_done", {30'b0, done, out_valid}, 32'd0);
    rst = 0;
    run(make_a(16'h1000, 16'h1000, 16'h1000), 20'h0, 20'h08000, 32'h22222222, 0, 0);
    run(make_a(16'h2000, 16'h0800, 16'h0001), 20'h04000, 20'h10000, 32'h00000012, 0, 0);
    run(make_a(16'hFFFF, 16'hFFFF, 16'hFFFF), 20'h0, 20'h7FFF8, 32'h22222222, 0, 0);
    run(make_a(16'hFFFF, 16'hFFFF, 16'hFFFF), 20'h0, 20'h7FFF9, 32'h11111111, 0, 0);
    run(make_a(16'hFFFF, 16'hFFFF, 16'hFFFF), 20'hFFFFF, 20'h7FFF8, 32'h22222222, 0, 0);
    run(make_a(16'h2000, 16'h0800, 16'h0001), 20'h04000, 20'h10000, 32'h00000012, 1, 0);
    @(negedge clk);
    A_in = make_a(16'h1000, 16'h1000, 16'h1000); thr_lo = 0; thr_hi = 20'h08000; start = 1;
    @(negedge clk);
    start = 0;
    for (n = 1; n < 6; n++) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrun_reset_codes", tp_packed(), 32'h22222222);
    chk("midrun_reset_done", {30'b0, done, out_valid}, 32'd0);
    rst = 0;
    repeat (15) @(negedge clk);
    run(make_a(16'h2000, 16'h0800, 16'h0001), 20'h04000, 20'h10000, 32'h00000012, 0, 0);
    run(make_a(16'hFFFF, 16'hFFFF, 16'hFFFF), 20'h0, 20'h7FFF9, 32'h11111111, 0, 0);
    run(make_a(16'h2000, 16'h0800, 16'h0001), 20'h04000, 20'h10000, 32'h00000012, 2, 32'h11111111);
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
